multicycle_ctrl: RTL

Multi-cycle main control unit for the MIPS-subset datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It produces the 3-bit `ALUOp_o` code that the ALU controller consumes, together with all datapath enables. It sits between the instruction register opcode field and the ALU controller, register file, PC and unified memory port. It also waits on a memory-ready handshake and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the MIPS-subset datapath: sequences
// FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and counts retirements.
module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  instr_op_i,
  input  logic        mem_ready_i,
  output logic [2:0]  state_o,
  output logic [2:0]  ALUOp_o,
  output logic        ALUSrc_o,
  output logic        RegDst_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        IorD_o,
  output logic        IRWrite_o,
  output logic        PCWrite_o,
  output logic        PCSrc_o,
  output logic        Branch_o,
  output logic        BranchType_o,
  output logic        illegal_o,
  output logic [15:0] instr_cnt_o
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned ALU_W = 3;

  localparam logic [OP_W-1:0] OP_R    = 6'h00;
  localparam logic [OP_W-1:0] OP_J    = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE  = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI = 6'h0A;
  localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI  = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW   = 6'h23;
  localparam logic [OP_W-1:0] OP_SW   = 6'h2B;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [OP_W-1:0]    op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               retire_c;

  logic [ALU_W-1:0]   alu_op_c;
  logic               alu_src_c, reg_dst_c, reg_write_c, mem_to_reg_c;
  logic               mem_read_c, mem_write_c, iord_c, ir_write_c;
  logic               pc_write_c, pc_src_c, branch_c, branch_type_c, illegal_c;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ORI, OP_LUI, OP_LW, OP_SW: is_legal = 1'b1;
      default:                      is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [ALU_W-1:0] alu_class(input logic [OP_W-1:0] op);
    case (op)
      OP_R:                alu_class = 3'b001;
      OP_ADDI, OP_LW, OP_SW: alu_class = 3'b010;
      OP_SLTI:             alu_class = 3'b011;
      OP_BEQ:              alu_class = 3'b100;
      OP_LUI:              alu_class = 3'b101;
      OP_ORI:              alu_class = 3'b110;
      OP_BNE:              alu_class = 3'b111;
      default:             alu_class = 3'b000;
    endcase
  endfunction

  function automatic logic uses_imm(input logic [OP_W-1:0] op);
    case (op)
      OP_ADDI, OP_SLTI, OP_LUI, OP_ORI, OP_LW, OP_SW: uses_imm = 1'b1;
      default:                                        uses_imm = 1'b0;
    endcase
  endfunction

  // State, latched opcode and retirement counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= instr_op_i;
      if (retire_c)            cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next-state and datapath decode; FETCH/MEM ready terms are Mealy
  always_comb begin
    state_d       = state_q;
    retire_c      = 1'b0;
    alu_op_c      = '0;
    alu_src_c     = 1'b0;
    reg_dst_c     = 1'b0;
    reg_write_c   = 1'b0;
    mem_to_reg_c  = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    iord_c        = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    pc_src_c      = 1'b0;
    branch_c      = 1'b0;
    branch_type_c = 1'b0;
    illegal_c     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        ir_write_c = mem_ready_i;
        pc_write_c = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (instr_op_i == OP_J) begin
          pc_write_c = 1'b1;
          pc_src_c   = 1'b1;
          retire_c   = 1'b1;
          state_d    = S_FETCH;
        end else if (!is_legal(instr_op_i)) begin
          illegal_c  = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op_c  = alu_class(op_q);
        alu_src_c = uses_imm(op_q);
        case (op_q)
          OP_BEQ, OP_BNE: begin
            branch_c      = 1'b1;
            branch_type_c = (op_q == OP_BNE);
            retire_c      = 1'b1;
            state_d       = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        iord_c      = 1'b1;
        alu_src_c   = 1'b1;
        alu_op_c    = 3'b010;
        mem_read_c  = (op_q == OP_LW);
        mem_write_c = (op_q == OP_SW);
        if (mem_ready_i) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            retire_c = (op_q == OP_SW);
            state_d  = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = (op_q == OP_R);
        mem_to_reg_c = (op_q == OP_LW);
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every output, including the Mealy terms
  assign state_o      = state_q;
  assign instr_cnt_o  = cnt_q;
  assign ALUOp_o      = alu_op_c & {ALU_W{rst_i}};
  assign ALUSrc_o     = alu_src_c     & rst_i;
  assign RegDst_o     = reg_dst_c     & rst_i;
  assign RegWrite_o   = reg_write_c   & rst_i;
  assign MemtoReg_o   = mem_to_reg_c  & rst_i;
  assign MemRead_o    = mem_read_c    & rst_i;
  assign MemWrite_o   = mem_write_c   & rst_i;
  assign IorD_o       = iord_c        & rst_i;
  assign IRWrite_o    = ir_write_c    & rst_i;
  assign PCWrite_o    = pc_write_c    & rst_i;
  assign PCSrc_o      = pc_src_c      & rst_i;
  assign Branch_o     = branch_c      & rst_i;
  assign BranchType_o = branch_type_c & rst_i;
  assign illegal_o    = illegal_c     & rst_i;

endmodule
